uart_tx: RTL

Serial transmitter for the UART controller. It is the outbound counterpart of the rx-line input synchronizer: it takes parallel bytes from the core clock domain over a valid/ready handshake and drives an asynchronous UART frame on tx_o. The frame is start bit, data LSB-first, optional parity, then stop bit(s). It sits between the TX FIFO/register interface and the pad.

---
 rtl/uart_tx.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART serial transmitter: valid/ready byte input, start + LSB-first data + stop frame on tx_o.
// Optional parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
`ifdef UART_TX_PARITY_EN
  parameter int PARITY_ODD   = 0,
`endif
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 tx_busy_o,
  output logic                 tx_done_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                 r_state;
  logic [BAUD_W-1:0]      r_baud;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_tx;
  logic                   r_ready;
  logic                   r_busy;
  logic                   r_done;
  logic [DATA_BITS-1:0]   r_shift;
`ifdef UART_TX_PARITY_EN
  logic                   r_par;
`endif

  logic w_accept;
  logic w_bit_end;

  assign w_accept  = tx_valid_i && r_ready;
  assign w_bit_end = (r_baud == BAUD_LAST);

  // r_idx counts data bits in DATA and stop bits in STOP
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_idx   <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_accept) begin
          r_state <= S_START;
          r_tx    <= 1'b0;
          r_ready <= 1'b0;
          r_busy  <= 1'b1;
          r_baud  <= '0;
          r_idx   <= '0;
        end
      end else begin
        r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
        if (w_bit_end) begin
          case (r_state)
            S_START: begin
              r_state <= S_DATA;
              r_tx    <= r_shift[0];
              r_idx   <= '0;
            end
            S_DATA: begin
              if (r_idx == IDX_LAST) begin
                r_idx <= '0;
`ifdef UART_TX_PARITY_EN
                r_state <= S_PARITY;
                r_tx    <= r_par;
`else
                r_state <= S_STOP;
                r_tx    <= 1'b1;
`endif
              end else begin
                r_idx <= r_idx + 1'b1;
                r_tx  <= r_shift[1];
              end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
              r_idx   <= '0;
            end
`endif
            S_STOP: begin
              if (r_idx == STOP_LAST) begin
                r_state <= S_IDLE;
                r_ready <= 1'b1;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_idx   <= '0;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  // Payload path: loaded whenever IDLE sees valid (that is exactly acceptance), then shifted per data bit
  always_ff @(posedge clk_i) begin
    if (r_state == S_IDLE && tx_valid_i) begin
      r_shift <= tx_data_i;
`ifdef UART_TX_PARITY_EN
      r_par   <= (PARITY_ODD != 0) ? ~^tx_data_i : ^tx_data_i;
`endif
    end else if (r_state == S_DATA && w_bit_end) begin
      r_shift <= r_shift >> 1;
    end
  end

  assign tx_o       = r_tx;
  assign tx_ready_o = r_ready;
  assign tx_busy_o  = r_busy;
  assign tx_done_o  = r_done;

endmodule
